// File: rtl/bocks_pkg.sv
// Shared definitions for the bocks framebuffer path: geometry defaults,
// CPU write-port widths and the rectangle-fill state encoding.
package bocks_pkg;

  localparam int DEFAULT_FB_WIDTH  = 640;
  localparam int DEFAULT_FB_HEIGHT = 480;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    RUN,
    DONE
  } fill_state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clipper: trims a rectangle to the framebuffer and computes
// the byte address of its top-left pixel.
module rect_clip
  import bocks_pkg::*;
#(
  parameter int                    FB_WIDTH  = DEFAULT_FB_WIDTH,
  parameter int                    FB_HEIGHT = DEFAULT_FB_HEIGHT,
  parameter logic [CPU_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [9:0]            x0,
  input  logic [9:0]            y0,
  input  logic [10:0]           w,
  input  logic [10:0]           h,
  output logic [10:0]           cw,
  output logic [10:0]           ch,
  output logic [CPU_ADDR_W-1:0] start_addr
);

  localparam logic [10:0]           FBW    = 11'(FB_WIDTH);
  localparam logic [10:0]           FBH    = 11'(FB_HEIGHT);
  localparam logic [CPU_ADDR_W-1:0] STRIDE = CPU_ADDR_W'(FB_WIDTH);

  logic [10:0] room_x;
  logic [10:0] room_y;

  // Room is only meaningful when the origin lies inside the framebuffer.
  always_comb begin
    room_x = FBW - {1'b0, x0};
    room_y = FBH - {1'b0, y0};
    cw     = '0;
    ch     = '0;
    if ({1'b0, x0} < FBW) cw = (w < room_x) ? w : room_x;
    if ({1'b0, y0} < FBH) ch = (h < room_y) ? h : room_y;
    start_addr = BASE_ADDR + CPU_ADDR_W'(y0) * STRIDE + CPU_ADDR_W'(x0);
  end

endmodule

// File: rtl/rect_fill_writer.sv
// Fills a clipped rectangle of the framebuffer with one colour, issuing one
// byte write per accepted cycle on the vga CPU port.
module rect_fill_writer
  import bocks_pkg::*;
#(
  parameter int                    FB_WIDTH  = DEFAULT_FB_WIDTH,
  parameter int                    FB_HEIGHT = DEFAULT_FB_HEIGHT,
  parameter logic [CPU_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [9:0]            x0,
  input  logic [9:0]            y0,
  input  logic [10:0]           w,
  input  logic [10:0]           h,
  input  logic [CPU_DATA_W-1:0] color,
  input  logic                  wr_ready,
  output logic                  cpu_wr,
  output logic [CPU_ADDR_W-1:0] cpu_addr,
  output logic [CPU_DATA_W-1:0] cpu_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CPU_ADDR_W-1:0] STRIDE = CPU_ADDR_W'(FB_WIDTH);

  fill_state_t           state_q, state_n;
  logic [9:0]            x0_q, x0_n, y0_q, y0_n;
  logic [10:0]           w_q, w_n, h_q, h_n;
  logic [10:0]           cw_q, cw_n, ch_q, ch_n;
  logic [10:0]           col_q, col_n, row_q, row_n;
  logic [CPU_ADDR_W-1:0] addr_q, addr_n, row_base_q, row_base_n;
  logic [CPU_DATA_W-1:0] color_q, color_n;
  logic                  wr_q, wr_n, busy_q, busy_n, done_q, done_n;

  logic [10:0]           clip_cw, clip_ch;
  logic [CPU_ADDR_W-1:0] clip_addr;
  logic                  accept;

  rect_clip #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .BASE_ADDR (BASE_ADDR)
  ) u_clip (
    .x0         (x0_q),
    .y0         (y0_q),
    .w          (w_q),
    .h          (h_q),
    .cw         (clip_cw),
    .ch         (clip_ch),
    .start_addr (clip_addr)
  );

  assign accept = wr_q && wr_ready;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      color_q    <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      x0_q       <= x0_n;
      y0_q       <= y0_n;
      w_q        <= w_n;
      h_q        <= h_n;
      cw_q       <= cw_n;
      ch_q       <= ch_n;
      col_q      <= col_n;
      row_q      <= row_n;
      addr_q     <= addr_n;
      row_base_q <= row_base_n;
      color_q    <= color_n;
      wr_q       <= wr_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  // The address is not advanced past the final pixel, so cpu_addr rests on
  // the last byte written rather than one beyond the clipped region.
  always_comb begin
    state_n    = state_q;
    x0_n       = x0_q;
    y0_n       = y0_q;
    w_n        = w_q;
    h_n        = h_q;
    cw_n       = cw_q;
    ch_n       = ch_q;
    col_n      = col_q;
    row_n      = row_q;
    addr_n     = addr_q;
    row_base_n = row_base_q;
    color_n    = color_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_n    = x0;
          y0_n    = y0;
          w_n     = w;
          h_n     = h;
          color_n = color;
          state_n = CLIP;
        end
      end
      CLIP: begin
        cw_n = clip_cw;
        ch_n = clip_ch;
        if (clip_cw == '0 || clip_ch == '0) begin
          state_n = DONE;
        end else begin
          col_n      = '0;
          row_n      = '0;
          addr_n     = clip_addr;
          row_base_n = clip_addr;
          state_n    = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (col_q == cw_q - 11'd1) begin
            if (row_q == ch_q - 11'd1) begin
              state_n = DONE;
            end else begin
              col_n      = '0;
              row_n      = row_q + 11'd1;
              row_base_n = row_base_q + STRIDE;
              addr_n     = row_base_q + STRIDE;
            end
          end else begin
            col_n  = col_q + 11'd1;
            addr_n = addr_q + 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    wr_n   = (state_n == RUN);
    busy_n = (state_n == CLIP) || (state_n == RUN);
    done_n = (state_n == DONE);
  end

  assign cpu_wr   = wr_q;
  assign cpu_addr = addr_q;
  assign cpu_data = color_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Scoreboard bench for rect_fill_writer: stimulus queues hand-computed writes,
// a negedge monitor compares every presented write against the queue head.
module tb_rect_fill_writer;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  x0, y0;
  logic [10:0] w, h;
  logic [7:0]  color;
  logic        wr_ready;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [39:0] exp_q[$];
  int acc_count, busy_cnt, done_count, done_cyc, first_wr_cyc;
  bit done_seen;
  logic bp_pat[8];
  int bp_len = 0;

  rect_fill_writer dut (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .wr_ready (wr_ready),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [7:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Monitor: any presented write must match the queue head; pop on acceptance.
  always @(negedge cpu_clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_count++;
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (cpu_wr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0h, expected no write",
                   cpu_addr, cpu_data);
        end else begin
          check_output("write_addr_data", {24'd0, cpu_addr, cpu_data}, {24'd0, exp_q[0]});
          if (wr_ready) begin
            void'(exp_q.pop_front());
            acc_count++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [9:0] ax0, input logic [9:0] ay0,
                                input logic [10:0] aw, input logic [10:0] ah,
                                input logic [7:0] acolor, input int exp_writes,
                                input int exp_done_off, input int exp_busy);
    int start_cyc;
    acc_count    = 0;
    busy_cnt     = 0;
    done_count   = 0;
    done_seen    = 1'b0;
    done_cyc     = 0;
    first_wr_cyc = -1;
    @(posedge cpu_clk); #1;
    x0 = ax0; y0 = ay0; w = aw; h = ah; color = acolor; start = 1'b1;
    start_cyc = cyc;
    @(posedge cpu_clk); #1;
    start = 1'b0;
    for (int i = 0; i < bp_len; i++) begin
      @(posedge cpu_clk); #1;
      wr_ready = bp_pat[i];
    end
    if (bp_len > 0) begin
      @(posedge cpu_clk); #1;
      wr_ready = 1'b1;
    end
    for (int t = 0; t < 400; t++) begin
      if (done_seen) break;
      @(posedge cpu_clk);
    end
    repeat (2) @(posedge cpu_clk);
    #1;
    check_output("done_seen", 64'(done_seen), 64'd1);
    check_output("done_latency", 64'(done_cyc - start_cyc), 64'(exp_done_off));
    check_output("write_count", 64'(acc_count), 64'(exp_writes));
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    check_output("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check_output("done_pulses", 64'(done_count), 64'd1);
    if (exp_writes > 0)
      check_output("first_write_latency", 64'(first_wr_cyc - start_cyc), 64'd2);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    acc_count = 0; busy_cnt = 0; done_count = 0; done_cyc = 0; first_wr_cyc = -1;
    done_seen = 1'b0;
    #1;
    check_output("reset_cpu_wr", 64'(cpu_wr), 64'd0);
    check_output("reset_cpu_addr", 64'(cpu_addr), 64'd0);
    check_output("reset_cpu_data", 64'(cpu_data), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    repeat (3) @(posedge cpu_clk);
    #1 reset = 1'b0;

    $display("[TB] basic fill");
    push_write(642, 8'hA5); push_write(643, 8'hA5); push_write(644, 8'hA5);
    push_write(1282, 8'hA5); push_write(1283, 8'hA5); push_write(1284, 8'hA5);
    apply_stimulus(10'd2, 10'd1, 11'd3, 11'd2, 8'hA5, 6, 8, 7);

    $display("[TB] clipping at bottom-right corner");
    push_write(307198, 8'h11); push_write(307199, 8'h11);
    apply_stimulus(10'd638, 10'd479, 11'd10, 11'd10, 8'h11, 2, 4, 3);
    check_output("clip_last_addr", 64'(cpu_addr), 64'd307199);

    $display("[TB] empty and off-screen rectangles");
    apply_stimulus(10'd4, 10'd4, 11'd0, 11'd5, 8'h22, 0, 2, 1);
    apply_stimulus(10'd700, 10'd0, 11'd5, 11'd5, 8'h33, 0, 2, 1);

    $display("[TB] backpressure");
    bp_pat[0] = 1; bp_pat[1] = 0; bp_pat[2] = 0; bp_pat[3] = 1;
    bp_pat[4] = 1; bp_pat[5] = 0; bp_pat[6] = 1;
    bp_len = 7;
    push_write(0, 8'h44); push_write(1, 8'h44); push_write(2, 8'h44); push_write(3, 8'h44);
    apply_stimulus(10'd0, 10'd0, 11'd4, 11'd1, 8'h44, 4, 9, 8);
    bp_len = 0;

    $display("[TB] start while busy");
    push_write(1290, 8'h5A); push_write(1291, 8'h5A); push_write(1292, 8'h5A);
    push_write(1930, 8'h5A); push_write(1931, 8'h5A); push_write(1932, 8'h5A);
    fork
      apply_stimulus(10'd10, 10'd2, 11'd3, 11'd2, 8'h5A, 6, 8, 7);
      begin
        repeat (4) @(posedge cpu_clk);
        #1 start = 1'b1; color = 8'hFF;
        @(posedge cpu_clk);
        #1 start = 1'b0;
      end
    join

    $display("[TB] reset mid-fill");
    acc_count = 0; done_count = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        push_write(32'(r * 640 + c), 8'h77);
    @(posedge cpu_clk); #1;
    x0 = 10'd0; y0 = 10'd0; w = 11'd10; h = 11'd10; color = 8'h77; start = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0;
    repeat (4) @(posedge cpu_clk);
    #3 reset = 1'b1;
    #1;
    check_output("abort_cpu_wr", 64'(cpu_wr), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_write_count", 64'(acc_count), 64'd3);
    exp_q.delete();
    repeat (2) @(posedge cpu_clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge cpu_clk);
    #1;
    check_output("after_abort_writes", 64'(acc_count), 64'd3);
    check_output("after_abort_done", 64'(done_count), 64'd0);

    $display("[TB] fresh fill after reset");
    push_write(5, 8'h3C); push_write(6, 8'h3C);
    apply_stimulus(10'd5, 10'd0, 11'd2, 11'd1, 8'h3C, 2, 4, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
